// File: rtl/cdb_broadcaster_if.sv
// ---------------------------------------------------------------------------
// cdb_broadcaster_if
// Purpose : bundles the result-source handshake between the functional units
//           and the CDB broadcaster.
// Signals : src_valid[i]  unit i offers a result
//           src_ready[i]  broadcaster accepts unit i's result this cycle
//           src_data      unit i result at [i*DW +: DW]
//           src_id        unit i ROB tag at [i*IW +: IW] (tag 0 = no entry)
//           src_int       unit i internal-computation flag
// Handshake: a transfer on source i happens at a rising edge where
//           src_valid[i] and src_ready[i] are both 1. src_ready may depend
//           combinationally on the broadcaster state and on cdb_stall/flush,
//           never on src_valid.
// Modports: master = functional-unit side, slave = broadcaster side.
// ---------------------------------------------------------------------------
interface cdb_broadcaster_if #(
  parameter int NSRC = 4,
  parameter int DW   = 32,
  parameter int IW   = 3
);
  logic [NSRC-1:0]    src_valid;
  logic [NSRC-1:0]    src_ready;
  logic [NSRC*DW-1:0] src_data;
  logic [NSRC*IW-1:0] src_id;
  logic [NSRC-1:0]    src_int;

  modport master (
    output src_valid, src_data, src_id, src_int,
    input  src_ready
  );

  modport slave (
    input  src_valid, src_data, src_id, src_int,
    output src_ready
  );
endinterface

// File: rtl/cdb_broadcaster.sv
// ---------------------------------------------------------------------------
// cdb_broadcaster
// Purpose : transmit side of the common data bus. Each functional unit owns a
//           one-entry slot; a round-robin arbiter picks one full slot per
//           output load and places it in a registered output stage that drives
//           the shared tri-state bus. The bus floats when nothing is broadcast.
// Ports   : clk, rst       clock, synchronous active-high reset
//           src            source handshake bundle (slave modport)
//           flush          drop every pending and broadcasting result
//           cdb_stall      listeners cannot take the current broadcast
//           cdb_valid      a broadcast is on the bus
//           cdbData/cdbId/cdbInt  tri-state broadcast payload
// Handshake: source i transfers at an edge where src_valid[i] & src_ready[i].
//           src_ready[i] = ~rst & ~flush & (slot empty | slot drains this cycle).
// ---------------------------------------------------------------------------
module cdb_broadcaster #(
  parameter int NSRC = 4,
  parameter int DW   = 32,
  parameter int IW   = 3
) (
  input  logic                clk,
  input  logic                rst,
  cdb_broadcaster_if.slave    src,
  input  logic                flush,
  input  logic                cdb_stall,
  output logic                cdb_valid,
  output tri   [DW-1:0]       cdbData,
  output tri   [IW-1:0]       cdbId,
  output tri                  cdbInt
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

  // Per-source slots
  logic [NSRC-1:0] full_q, full_d;
  logic [DW-1:0]   slot_data_q [NSRC];
  logic [DW-1:0]   slot_data_d [NSRC];
  logic [IW-1:0]   slot_id_q   [NSRC];
  logic [IW-1:0]   slot_id_d   [NSRC];
  logic [NSRC-1:0] slot_int_q, slot_int_d;

  // Output stage and arbiter pointer
  logic          bcast_valid_q, bcast_valid_d;
  logic [DW-1:0] bcast_data_q, bcast_data_d;
  logic [IW-1:0] bcast_id_q, bcast_id_d;
  logic          bcast_int_q, bcast_int_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  // Arbitration
  logic          load;
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW:0]   scan_sum;
  logic [PW-1:0] scan_idx;
  logic [NSRC-1:0] drain;
  logic [NSRC-1:0] ready;

  // The output stage can take a new result when empty or when the bus moves.
  assign load = ~bcast_valid_q | ~cdb_stall;

  // First full slot scanning upward from rr_ptr, wrapping at NSRC.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int i = 0; i < NSRC; i++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (scan_sum >= (PW+1)'(NSRC)) begin
        scan_sum = scan_sum - (PW+1)'(NSRC);
      end
      scan_idx = scan_sum[PW-1:0];
      if (!win_found && full_q[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    drain = '0;
    ready = '0;
    for (int i = 0; i < NSRC; i++) begin
      drain[i] = load & win_found & (win_idx == PW'(i));
      ready[i] = ~rst & ~flush & (~full_q[i] | drain[i]);
    end
  end

  assign src.src_ready = ready;

  always_comb begin
    full_d        = full_q;
    slot_data_d   = slot_data_q;
    slot_id_d     = slot_id_q;
    slot_int_d    = slot_int_q;
    bcast_valid_d = bcast_valid_q;
    bcast_data_d  = bcast_data_q;
    bcast_id_d    = bcast_id_q;
    bcast_int_d   = bcast_int_q;
    rr_ptr_d      = rr_ptr_q;

    if (load) begin
      bcast_valid_d = win_found;
      if (win_found) begin
        bcast_data_d    = slot_data_q[win_idx];
        bcast_id_d      = slot_id_q[win_idx];
        bcast_int_d     = slot_int_q[win_idx];
        full_d[win_idx] = 1'b0;
        rr_ptr_d        = (win_idx == PW'(NSRC-1)) ? '0 : win_idx + PW'(1);
      end
    end

    // Refill after drain so a same-cycle drain and handshake keeps the new
    // result. Tag 0 completes the handshake but leaves the slot empty.
    for (int i = 0; i < NSRC; i++) begin
      if (src.src_valid[i] && ready[i]) begin
        full_d[i]      = (src.src_id[i*IW +: IW] != '0);
        slot_data_d[i] = src.src_data[i*DW +: DW];
        slot_id_d[i]   = src.src_id[i*IW +: IW];
        slot_int_d[i]  = src.src_int[i];
      end
    end

    // Flush wins over everything, but the arbiter keeps its position.
    if (flush) begin
      full_d        = '0;
      bcast_valid_d = 1'b0;
      rr_ptr_d      = rr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q        <= '0;
      bcast_valid_q <= 1'b0;
      rr_ptr_q      <= '0;
    end else begin
      full_q        <= full_d;
      bcast_valid_q <= bcast_valid_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  // Payload registers are qualified by the full/valid bits and need no reset.
  always_ff @(posedge clk) begin
    slot_data_q  <= slot_data_d;
    slot_id_q    <= slot_id_d;
    slot_int_q   <= slot_int_d;
    bcast_data_q <= bcast_data_d;
    bcast_id_q   <= bcast_id_d;
    bcast_int_q  <= bcast_int_d;
  end

  assign cdb_valid = bcast_valid_q;
  assign cdbData   = bcast_valid_q ? bcast_data_q : 'z;
  assign cdbId     = bcast_valid_q ? bcast_id_q   : 'z;
  assign cdbInt    = bcast_valid_q ? bcast_int_q  : 1'bz;

endmodule
